// File: rtl/ehl_apb_pkg.sv
// Shared APB-side definitions: initiator FSM state encoding and timeout counter width.
package ehl_apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_TOCNT_W = 16;

endpackage

// File: rtl/ehl_generic2apb.sv
// APB3 initiator bridge: turns single host requests (req/wr/adr/wdata) into SETUP/ACCESS transfers.
// Define EHL_GENERIC2APB_TIMEOUT_EN to force-terminate ACCESS after TIMEOUT unready cycles.
module ehl_generic2apb
  import ehl_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADR_WIDTH-1:0]  adr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADR_WIDTH-1:0]  paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("ehl_generic2apb: TIMEOUT must be within 1..65535");
  end

  apb_state_e state, state_nxt;
  logic       done;
  logic       expire;
  logic       to_hit;

`ifdef EHL_GENERIC2APB_TIMEOUT_EN
  localparam logic [APB_TOCNT_W-1:0] TO_LAST = APB_TOCNT_W'(TIMEOUT - 1);
  logic [APB_TOCNT_W-1:0] to_cnt;

  // Hitting TIMEOUT-1 while still unready means this is the TIMEOUT-th waiting cycle.
  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt <= '0;
    end else if (state == APB_SETUP) begin
      to_cnt <= '0;
    end else if (state == APB_ACCESS && !pready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    expire    = 1'b0;
    case (state)
      APB_IDLE:   if (req) state_nxt = APB_SETUP;
      APB_SETUP:  state_nxt = APB_ACCESS;
      APB_ACCESS: begin
        if (pready) begin
          state_nxt = APB_IDLE;
          done      = 1'b1;
        end else if (to_hit) begin
          state_nxt = APB_IDLE;
          expire    = 1'b1;
        end
      end
      default:    state_nxt = APB_IDLE;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so all flops update together.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= APB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields are captured only on acceptance and held afterwards, so IDLE keeps the last transfer visible.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      if (state == APB_IDLE && req) begin
        paddr  <= adr;
        pwrite <= wr;
        pwdata <= wdata;
      end
      ack <= done | expire;
      err <= (done & pslverr) | expire;
      if (done && !pwrite) begin
        rdata <= prdata;
      end
    end
  end

  // Bus controls decode straight from state so an asynchronous reset drops them at once.
  assign psel    = (state == APB_SETUP) || (state == APB_ACCESS);
  assign penable = (state == APB_ACCESS);
  assign busy    = psel;

endmodule

// File: tb/tb_ehl_generic2apb.sv
// Scoreboard bench for ehl_generic2apb: host stimulus pushes expectations, a completer model
// answers on APB, and a monitor checks each ack against the transaction-level reference.
module tb_ehl_generic2apb;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef EHL_GENERIC2APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy, ack, err, pwrite, psel, penable;
  logic [DW-1:0] rdata, pwdata;
  logic [AW-1:0] paddr;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  ehl_generic2apb #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .wr(wr), .adr(adr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .err(err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          slverr;
    logic [DW-1:0] prdata;
    bit            stuck;
    int            exp_access;
  } xfer_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            ack_cyc;
  } resp_t;

  xfer_t         resp_q[$];
  resp_t         exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] last_rdata = '0;
  bit            hold_stuck = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic xfer_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int waits, input logic se, input logic [DW-1:0] rd,
                               input bit stuck);
    xfer_t x;
    x.wr = w; x.adr = a; x.wdata = d; x.waits = waits;
    x.slverr = se; x.prdata = rd; x.stuck = stuck; x.exp_access = 0;
    return x;
  endfunction

  // Reference model: one transfer, expected response derived from the protocol rules.
  task automatic issue(input xfer_t x, input bit violate);
    resp_t e;
    bit    tmo;
`ifdef EHL_GENERIC2APB_TIMEOUT_EN
    tmo = x.stuck;
`else
    tmo = 1'b0;
`endif
    e.err = tmo ? 1'b1 : x.slverr;
    if (!x.wr && !tmo) last_rdata = x.prdata;
    e.rdata = last_rdata;
    if (tmo)          e.ack_cyc = cyc + 2 + TO;
    else if (x.stuck) e.ack_cyc = -1;
    else              e.ack_cyc = cyc + 3 + x.waits;
    if (tmo)          x.exp_access = TO;
    else if (x.stuck) x.exp_access = 0;
    else              x.exp_access = x.waits + 1;
    exp_q.push_back(e);
    resp_q.push_back(x);
    if (x.stuck) hold_stuck = 1'b1;
    req = 1'b1; wr = x.wr; adr = x.adr; wdata = x.wdata;
    @(negedge pclk);
    if (violate) begin
      wr = ~x.wr; adr = $urandom; wdata = $urandom;
      @(negedge pclk);
    end
    req = 1'b0; wr = 1'($urandom); adr = $urandom; wdata = $urandom;
  endtask

  task automatic wait_ack();
    int b;
    b = 300;
    while (!ack && b > 0) begin
      @(negedge pclk);
      b--;
    end
    check("ack_seen", ack, 1);
  endtask

  // APB completer model: inserts the requested wait states, checks the bus fields.
  initial begin
    xfer_t cur;
    int    rem;
    int    acc;
    bit    active;
    rem = 0; acc = 0; active = 1'b0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        active = 1'b0;
        pready = 1'b0;
      end else if (psel && !penable) begin
        if (resp_q.size() == 0) begin
          check("unexpected_setup", psel, 0);
          active = 1'b0;
        end else begin
          cur = resp_q.pop_front();
          rem = cur.waits; acc = 0; active = 1'b1;
        end
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end else if (psel && penable && active) begin
        acc++;
        check("paddr", paddr, cur.adr);
        check("pwrite", pwrite, cur.wr);
        check("pwdata", pwdata, cur.wdata);
        pready = (rem == 0) && !(cur.stuck && hold_stuck);
        if (rem > 0) rem--;
        pslverr = pready ? cur.slverr : 1'($urandom);
        prdata  = pready ? cur.prdata : $urandom;
      end else begin
        if (active && !psel) begin
          if (cur.exp_access > 0) check("access_cycles", acc, cur.exp_access);
          active = 1'b0;
        end
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end
    end
  end

  // Monitor: pops one expectation per ack pulse.
  initial begin
    resp_t e;
    bit    prev;
    prev = 1'b0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        prev = 1'b0;
      end else if (ack) begin
        check("ack_gap", prev, 0);
        check("psel_at_ack", psel, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", ack, 0);
        end else begin
          e = exp_q.pop_front();
          check("err", err, e.err);
          check("rdata", rdata, e.rdata);
          if (e.ack_cyc >= 0) check("ack_latency", cyc, e.ack_cyc);
        end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    xfer_t x;
    int    bad;

    @(negedge pclk);
    check("rst_psel", psel, 0);     check("rst_penable", penable, 0);
    check("rst_busy", busy, 0);     check("rst_ack", ack, 0);
    check("rst_err", err, 0);       check("rst_rdata", rdata, 0);
    check("rst_paddr", paddr, 0);   check("rst_pwrite", pwrite, 0);
    check("rst_pwdata", pwdata, 0);
    presetn = 1'b1;
    @(negedge pclk);

    issue(mk(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, '0, 1'b0), 1'b0);
    wait_ack();
    @(negedge pclk);
    issue(mk(1'b0, 32'h20, '0, 3, 1'b0, 32'h1234_5678, 1'b0), 1'b0);
    wait_ack();
    issue(mk(1'b1, 32'h30, 32'h5555_AAAA, 0, 1'b1, 32'hFFFF_0000, 1'b0), 1'b0);
    wait_ack();
    issue(mk(1'b0, 32'h34, '0, 0, 1'b0, 32'hCAFE_F00D, 1'b0), 1'b0);
    wait_ack();

    // Back-to-back reads, with an illegal req held through the first SETUP.
    issue(mk(1'b0, 32'h0, '0, 0, 1'b0, $urandom, 1'b0), 1'b1);
    wait_ack();
    issue(mk(1'b0, 32'h4, '0, 0, 1'b0, $urandom, 1'b0), 1'b0);
    wait_ack();

    // Reset in the middle of ACCESS.
    issue(mk(1'b0, 32'h40, '0, 5, 1'b0, $urandom, 1'b0), 1'b0);
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("midrst_psel", psel, 0);
    check("midrst_penable", penable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ack", ack, 0);
    exp_q.delete();
    resp_q.delete();
    last_rdata = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    issue(mk(1'b0, 32'h44, '0, 1, 1'b0, 32'h0BAD_CAFE, 1'b0), 1'b0);
    wait_ack();

    // Completer that never becomes ready.
`ifdef EHL_GENERIC2APB_TIMEOUT_EN
    issue(mk(1'b0, 32'h50, '0, 0, 1'b0, $urandom, 1'b1), 1'b0);
    wait_ack();
    hold_stuck = 1'b0;
`else
    issue(mk(1'b0, 32'h50, '0, 0, 1'b0, $urandom, 1'b1), 1'b0);
    bad = 0;
    repeat (1000) begin
      @(negedge pclk);
      if (!psel) bad++;
    end
    check("psel_hold", bad, 0);
    hold_stuck = 1'b0;
    wait_ack();
`endif

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(1, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge pclk);
      x = mk(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, int'($urandom_range(3, 0)),
             ($urandom_range(7, 0) == 0), $urandom, 1'b0);
      issue(x, ($urandom_range(3, 0) == 0));
      wait_ack();
    end

    repeat (5) @(negedge pclk);
    check("exp_drained", exp_q.size(), 0);
    check("resp_drained", resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
